// File: rtl/mac_tap_sequencer.sv
// Delay line plus coefficient bank that streams one sample's taps as even/odd
// (data, coeff) pairs, TAPS/2 pairs per accepted sample, for a multiply-add tree.
module mac_tap_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COEFF_WIDTH = 8,
  parameter int unsigned TAPS        = 8,
  localparam int unsigned AW         = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   coeff_wr_en,
  input  logic [AW-1:0]          coeff_wr_addr,
  input  logic [COEFF_WIDTH-1:0] coeff_wr_data,
  input  logic                   clear,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   s_ready,
  output logic [DATA_WIDTH-1:0]  data1,
  output logic [DATA_WIDTH-1:0]  data2,
  output logic [COEFF_WIDTH-1:0] coeff1,
  output logic [COEFF_WIDTH-1:0] coeff2,
  output logic                   pair_valid,
  output logic                   pair_first,
  output logic                   pair_last,
  output logic                   busy
);

  localparam int unsigned NPAIRS = TAPS / 2;
  localparam int unsigned KW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NPAIRS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [DATA_WIDTH-1:0]  tap  [TAPS];
  logic [COEFF_WIDTH-1:0] coef [TAPS];
  logic                   accept;
  logic                   clear_ok;
  logic                   last_c;
  logic                   addr_ok;
  logic [AW-1:0]          idx_even;
  logic [AW-1:0]          idx_odd;

  assign accept   = s_valid && (state_q == IDLE);
  assign clear_ok = clear && (state_q == IDLE);
  assign last_c   = (state_q == RUN) && (k_q == KLAST);
  assign idx_even = AW'({k_q, 1'b0});
  assign idx_odd  = idx_even | AW'(1);

  // Address range check only matters when TAPS is not a power of two.
  if (TAPS == (1 << AW)) begin : g_full_range
    assign addr_ok = 1'b1;
  end else begin : g_part_range
    assign addr_ok = 32'(coeff_wr_addr) < TAPS;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Delay line: clear and accept on the same edge leave only the new sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(TAPS); i++) tap[i] <= '0;
    end else if (accept) begin
      tap[0] <= s_data;
      for (int i = 1; i < int'(TAPS); i++) tap[i] <= clear ? '0 : tap[i-1];
    end else if (clear_ok) begin
      for (int i = 0; i < int'(TAPS); i++) tap[i] <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(TAPS); i++) coef[i] <= '0;
    end else if (coeff_wr_en && addr_ok) begin
      coef[coeff_wr_addr] <= coeff_wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    data1      = '0;
    data2      = '0;
    coeff1     = '0;
    coeff2     = '0;
    pair_valid = 1'b0;
    pair_first = 1'b0;
    pair_last  = 1'b0;
    busy       = 1'b0;
    s_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = reset;
        if (accept) begin
          state_d = RUN;
          k_d     = '0;
        end
      end
      RUN: begin
        busy       = 1'b1;
        pair_valid = 1'b1;
        pair_first = (k_q == '0);
        pair_last  = last_c;
        data1      = tap[idx_even];
        data2      = tap[idx_odd];
        coeff1     = coef[idx_even];
        coeff2     = coef[idx_odd];
        if (last_c) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
